st2bus_pack: RTL and testbench
==============================

// Module: st2bus_pack
// PURPOSE
//  Return-path packer: takes the 8-bit Avalon-ST stream of decoded turbo packets and packs it into
//  BUS-wide words with a header, driven onto the host bus through a bus_en/bus_ready handshake.
//  Sits after the decoder output mux. It mirrors the input-side bus-to-stream splitting in the reverse direction.
// PARAMETERS
//  BUS          534  bus word width; must equal SYM_PER_BUS*ST + 22
//  ST           8    stream symbol width
//  SYM_PER_BUS  64   symbols per bus word (payload 512 bits)
// PORTS
//  clk        in   1    single clock, all logic
//  rst_n      in   1    asynchronous active-low reset
//  st_data    in   ST   stream symbol
//  st_valid   in   1    symbol valid
//  st_sop     in   1    first symbol of packet
//  st_eop     in   1    last symbol of packet
//  st_ready   out  1    packer accepts symbol (registered)
//  bus_data   out  BUS  packed word
//  bus_en     out  1    bus_data valid
//  bus_ready  in   1    host accepts word
//  err_cnt    out  16   protocol-violation count, saturating
// BEHAVIOUR
//  - Reset (async, rst_n=0): st_ready=0, bus_en=0, bus_data=0, err_cnt=0, seq=0, widx=0, FSM=IDLE, acc empty.
//    st_ready goes to 1 on the first clk edge after rst_n deasserts. Reset mid-packet discards all partial data.
//  - Symbol accept: st_valid & st_ready. Word accept: bus_en & bus_ready.
//  - bus_data and bus_en stay stable until the word is accepted.
//  - Word layout:
//      [8k+7:8k]  symbol k, for k = 0..nsym-1; unused symbol slots are 0
//      [518:512]  nsym (1..64)
//      [519]      sop word flag
//      [520]      eop word flag
//      [528:521]  pkt_seq
//      [533:529]  word_idx (within packet, wraps mod 32)
//  - FSM states:
//      IDLE: accepted symbol with sop -> FILL (stores symbol 0). If eop is also set, a one-symbol word is emitted and the FSM stays IDLE.
//            Accepted symbol without sop -> dropped, err_cnt++.
//      FILL: accepted symbols append to the accumulator. An accepted sop in FILL is treated as data and err_cnt++.
//            Word completes on the 64th symbol or on eop. Eop -> IDLE and pkt_seq++ (8-bit wrap 255->0).
//      HOLD: a word is complete but the output register is occupied. st_ready=0. Go to FILL or IDLE once the word moves to the output register.
//  - The completing symbol is merged straight into the output register when the register is empty or is accepted in the same cycle.
//    bus_en rises on the cycle after the completing symbol. Full rate: one symbol per clk with no bubbles while bus_ready=1.
//  - Otherwise the word is held in the accumulator (HOLD). st_ready drops on the next cycle.
//    The move happens on the cycle the output is accepted, and st_ready returns to 1 on the following cycle.
//  - widx resets to 0 at sop and increments per emitted word. The sop flag is set only on the word holding symbol 0.
//  - Simultaneous events: word accept and new word load in the same cycle means bus_en stays 1 with the new data.
//    err_cnt saturates at 0xFFFF.
// TESTING
//  1. 128-symbol packet (values 0..127), bus_ready=1 -> 2 words:
//       word0: nsym=64, sop=1, eop=0, widx=0.
//       word1: nsym=64, sop=0, eop=1, widx=1.
//       seq=0 on both; st_ready stays 1 throughout.
//  2. 130-symbol packet -> 3 words; the last word has nsym=2, eop=1, bits[511:16]=0.
//  3. Single symbol 0xA5 with sop=eop=1 -> one word: nsym=1, sop=1, eop=1, [7:0]=0xA5; the next packet has seq=1.
//  4. bus_ready=0 during two back-to-back 64-symbol packets -> word0 held stable; word1 completes -> HOLD, st_ready=0.
//     Raise bus_ready -> both words delivered in order; st_ready returns to 1.
//  5. st_valid without sop in IDLE (3 symbols) -> no bus_en, err_cnt=3. Sop inside a packet -> err_cnt+1, data packed normally.
//  6. rst_n pulsed low after 30 symbols -> all outputs 0. The next packet starts at widx=0, seq=0. 256 packets -> seq wraps 255->0.

Source files
------------

// File: rtl/st2bus_pack.sv
// Return-path packer: collects 8-bit stream symbols into bus-wide words with a header
// and presents them on the host bus through a bus_en/bus_ready handshake.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   st_data/st_valid      stream symbol and its valid
//   st_sop/st_eop         packet boundary markers
//   st_ready              packer accepts a symbol (registered)
//   bus_data/bus_en       packed word and its valid; stable until accepted
//   bus_ready             host accepts the word
//   err_cnt               saturating protocol-violation count
module st2bus_pack #(
  parameter int unsigned BUS         = 534,
  parameter int unsigned ST          = 8,
  parameter int unsigned SYM_PER_BUS = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [ST-1:0]  st_data,
  input  logic           st_valid,
  input  logic           st_sop,
  input  logic           st_eop,
  output logic           st_ready,
  output logic [BUS-1:0] bus_data,
  output logic           bus_en,
  input  logic           bus_ready,
  output logic [15:0]    err_cnt
);

  localparam int unsigned PAY = SYM_PER_BUS * ST;
  localparam int unsigned CW  = $clog2(SYM_PER_BUS + 1);
  localparam int unsigned SW  = $clog2(SYM_PER_BUS);

  // Header occupies the bits above the payload, nsym in the lowest position
  typedef struct packed {
    logic [4:0]    widx;
    logic [7:0]    seq;
    logic          eop;
    logic          sop;
    logic [CW-1:0] nsym;
  } hdr_t;

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  state_t         state, state_d;
  logic [PAY-1:0] acc_data;
  logic [CW-1:0]  acc_cnt;
  logic           acc_sop;
  hdr_t           hold_hdr;
  logic [7:0]     seq;
  logic [4:0]     widx;

  logic           sym_acc, out_free;
  logic           start, append, complete, mv_hold, err_inc, st_ready_d;
  logic [CW-1:0]  base_cnt;
  logic [4:0]     cur_widx;
  logic [PAY-1:0] merged;
  hdr_t           word_hdr;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next state, control strobes and the candidate word with the incoming symbol merged in
  always_comb begin
    sym_acc  = st_valid & st_ready;
    out_free = ~bus_en | bus_ready;
    state_d  = state;
    start    = 1'b0;
    append   = 1'b0;
    complete = 1'b0;
    mv_hold  = 1'b0;
    err_inc  = 1'b0;
    unique case (state)
      IDLE: if (sym_acc) begin
        if (st_sop) begin
          start    = 1'b1;
          complete = st_eop;
          state_d  = FILL;
        end else begin
          err_inc = 1'b1;
        end
      end
      FILL: if (sym_acc) begin
        append   = 1'b1;
        err_inc  = st_sop;
        complete = st_eop | (acc_cnt == CW'(SYM_PER_BUS - 1));
      end
      HOLD: if (bus_ready) begin
        mv_hold = 1'b1;
        state_d = hold_hdr.eop ? IDLE : FILL;
      end
      default: state_d = IDLE;
    endcase
    // A finished word either goes straight out or parks in the accumulator
    if (complete) state_d = !out_free ? HOLD : (st_eop ? IDLE : FILL);
    st_ready_d = (state_d != HOLD);

    base_cnt = start ? '0 : acc_cnt;
    cur_widx = start ? '0 : widx;
    merged   = start ? '0 : acc_data;
    merged[ST*base_cnt[SW-1:0] +: ST] = st_data;
    word_hdr.widx = cur_widx;
    word_hdr.seq  = seq;
    word_hdr.eop  = st_eop;
    word_hdr.sop  = start | acc_sop;
    word_hdr.nsym = base_cnt + CW'(1);
  end

  // Datapath: accumulator, output register, counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_ready <= 1'b0;
      bus_data <= '0;
      bus_en   <= 1'b0;
      err_cnt  <= '0;
      acc_data <= '0;
      acc_cnt  <= '0;
      acc_sop  <= 1'b0;
      hold_hdr <= '0;
      seq      <= '0;
      widx     <= '0;
    end else begin
      st_ready <= st_ready_d;
      if (err_inc && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      if (bus_en && bus_ready) bus_en <= 1'b0;
      if (complete) begin
        widx <= cur_widx + 5'd1;
        if (st_eop) seq <= seq + 8'd1;
        if (out_free) begin
          bus_data <= {word_hdr, merged};
          bus_en   <= 1'b1;
          acc_data <= '0;
          acc_cnt  <= '0;
          acc_sop  <= 1'b0;
        end else begin
          acc_data <= merged;
          hold_hdr <= word_hdr;
        end
      end else if (start || append) begin
        acc_data <= merged;
        acc_cnt  <= base_cnt + CW'(1);
        acc_sop  <= start | acc_sop;
        widx     <= cur_widx;
      end else if (mv_hold) begin
        // Held word replaces the one being accepted this cycle; bus_en stays high
        bus_data <= {hold_hdr, acc_data};
        bus_en   <= 1'b1;
        acc_data <= '0;
        acc_cnt  <= '0;
        acc_sop  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_st2bus_pack.sv
// Scoreboard bench for st2bus_pack: stimulus pushes expected words, a negedge monitor
// pops and compares every accepted word and checks hold stability while stalled.
module tb_st2bus_pack;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   st_data;
  logic         st_valid, st_sop, st_eop;
  logic         st_ready;
  logic [533:0] bus_data;
  logic         bus_en;
  logic         bus_ready;
  logic [15:0]  err_cnt;

  int errors = 0;
  int checks = 0;
  int stalls = 0;
  logic [7:0]   mseq = 8'd0;
  logic [533:0] sb[$];
  logic         pend = 1'b0;
  logic [533:0] pend_data;
  logic [533:0] exp_w;

  always #5 clk = ~clk;

  st2bus_pack dut (
    .clk(clk), .rst_n(rst_n),
    .st_data(st_data), .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop),
    .st_ready(st_ready),
    .bus_data(bus_data), .bus_en(bus_en), .bus_ready(bus_ready),
    .err_cnt(err_cnt)
  );

  // Monitor: compare every accepted word, and check a stalled word stays put
  always @(negedge clk) begin
    if (rst_n) begin
      if (pend) begin
        checks++;
        if (!bus_en || bus_data !== pend_data) begin
          errors++;
          $display("FAIL hold_stable en=%0b got=%h exp=%h", bus_en, bus_data, pend_data);
        end
      end
      pend      = bus_en && !bus_ready;
      pend_data = bus_data;
      if (bus_en && bus_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word got=%h", bus_data);
        end else begin
          exp_w = sb.pop_front();
          if (bus_data !== exp_w) begin
            errors++;
            $display("FAIL word got=%h exp=%h", bus_data, exp_w);
          end
        end
      end
    end else begin
      pend = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [533:0] act, input logic [533:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [533:0] make_word(input logic [7:0] base, input int first, input int nsym,
                                             input logic sop, input logic eop,
                                             input logic [7:0] seq, input logic [4:0] widx);
    logic [533:0] w;
    w = '0;
    for (int k = 0; k < nsym; k++) w[8*k +: 8] = base + 8'(first + k);
    w[518:512] = 7'(nsym);
    w[519]     = sop;
    w[520]     = eop;
    w[528:521] = seq;
    w[533:529] = widx;
    return w;
  endfunction

  // Present one symbol from posedge+1 and hold it until accepted
  task automatic send_sym(input logic [7:0] d, input logic sop, input logic eop);
    bit ok;
    ok       = 1'b0;
    st_data  = d;
    st_sop   = sop;
    st_eop   = eop;
    st_valid = 1'b1;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      if (st_ready) ok = 1'b1;
      else          stalls++;
      @(posedge clk);
      #1;
    end
    st_valid = 1'b0;
    st_sop   = 1'b0;
    st_eop   = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout data=%0h", d);
    end
  endtask

  // Packet of n symbols base, base+1, ...; extra sop marker at index sop_at (-1: none)
  task automatic send_pkt(input int n, input logic [7:0] base, input int sop_at);
    int nw, ns;
    nw = (n + 63) / 64;
    for (int w = 0; w < nw; w++) begin
      ns = (n - 64*w > 64) ? 64 : n - 64*w;
      sb.push_back(make_word(base, 64*w, ns, w == 0, 64*w + ns == n, mseq, 5'(w)));
    end
    mseq = mseq + 8'd1;
    for (int i = 0; i < n; i++) send_sym(base + 8'(i), i == 0 || i == sop_at, i == n - 1);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((sb.size() != 0 || bus_en) && c < 5000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 5000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; st_data = '0; st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; bus_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_st_ready", 534'(st_ready), 534'(0));
    chk("rst_bus_en",   534'(bus_en),   534'(0));
    chk("rst_bus_data", bus_data,       534'(0));
    chk("rst_err_cnt",  534'(err_cnt),  534'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 534'(st_ready), 534'(1));

    // 128-symbol packet at full rate
    stalls = 0;
    send_pkt(128, 8'h00, -1);
    drain();
    chk("t1_no_stall", 534'(stalls), 534'(0));

    // 130 symbols: short tail word
    send_pkt(130, 8'h00, -1);
    drain();

    // single-symbol packet, then a packet carrying the next sequence number
    send_pkt(1, 8'hA5, -1);
    send_pkt(4, 8'h20, -1);
    drain();

    // host stalled across two back-to-back packets
    bus_ready = 1'b0;
    send_pkt(64, 8'h40, -1);
    send_pkt(64, 8'h80, -1);
    @(negedge clk);
    chk("t4_ready_low", 534'(st_ready), 534'(0));
    repeat (5) @(posedge clk);
    #1;
    bus_ready = 1'b1;
    drain();
    repeat (2) @(posedge clk);
    #1;
    chk("t4_ready_back", 534'(st_ready), 534'(1));

    // protocol violations
    chk("t5_err0", 534'(err_cnt), 534'(0));
    send_sym(8'h01, 1'b0, 1'b0);
    send_sym(8'h02, 1'b0, 1'b0);
    send_sym(8'h03, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_err3", 534'(err_cnt), 534'(3));
    send_pkt(10, 8'h10, 4);
    drain();
    chk("t5_err4", 534'(err_cnt), 534'(4));

    // reset mid-packet, then sequence wrap
    for (int i = 0; i < 30; i++) send_sym(8'(i), i == 0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("t6_st_ready", 534'(st_ready), 534'(0));
    chk("t6_bus_en",   534'(bus_en),   534'(0));
    chk("t6_bus_data", bus_data,       534'(0));
    chk("t6_err_cnt",  534'(err_cnt),  534'(0));
    mseq = 8'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_pkt(64, 8'h33, -1);
    for (int i = 1; i < 256; i++) send_pkt(1, 8'(i), -1);
    send_pkt(1, 8'hEE, -1);
    drain();
    chk("t6_sb_empty", 534'(sb.size()), 534'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
